// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: opcodes, FSM states, datapath select codes and control bundle
package multicycle_control_unit_pkg;
  typedef enum logic [2:0] {OP_LW, OP_SW, OP_ADD, OP_ADDI, OP_SUB, OP_JMP, OP_BEQ, OP_HALT} opcode_e;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_WB_MEM, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_WB_ALU, S_BRANCH, S_JUMP, S_HALT, S_TRAP
  } state_e;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_CMP = 2'b01, ALU_SUB = 2'b10;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_OUT = 2'b01, PCSRC_JMP = 2'b10;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_ONE = 2'b01, SRCB_IMM = 2'b10, SRCB_OFF = 2'b11;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       illegal;
  } ctrl_t;
  function automatic state_e decode_next(input opcode_e op);
    case (op)
      OP_LW, OP_SW:   return S_MEMADDR;
      OP_ADD, OP_SUB: return S_EXEC_R;
      OP_ADDI:        return S_EXEC_I;
      OP_BEQ:         return S_BRANCH;
      OP_JMP:         return S_JUMP;
      default:        return S_HALT;
    endcase
  endfunction
endpackage

// File: rtl/mcu_output_decode.sv
// mcu_output_decode: Moore control decode from state and latched opcode; fetch writes gated by mem_ready
module mcu_output_decode
  import multicycle_control_unit_pkg::*;
(
  input  state_e  state,
  input  opcode_e op_q,
  input  logic    mem_ready,
  output ctrl_t   ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.pc_src = PCSRC_ALU;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op = ALU_ADD;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_OFF;
        ctrl.alu_op = ALU_ADD;
      end
      S_MEMADDR, S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op = op_q == OP_SUB ? ALU_SUB : ALU_ADD;
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst = op_q != OP_ADDI;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op = ALU_CMP;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src = PCSRC_OUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src = PCSRC_JMP;
      end
      S_HALT: ctrl.halted = 1'b1;
      S_TRAP: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle instruction sequencer with memory handshake and retire counter
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic [1:0]          PCSrc,
  output logic                IorD,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state_o
);
  state_e state, next;
  opcode_e op_q;
  ctrl_t ctrl;
  logic [31:0] op_ext;
  logic retire;
  assign op_ext = 32'(opcode);
  always_comb begin
    next = state;
    case (state)
      S_IDLE:    next = start ? S_FETCH : S_IDLE;
      S_FETCH:   next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  next = op_ext > 32'd7 ? S_TRAP : decode_next(opcode_e'(opcode[2:0]));
      S_MEMADDR: next = op_q == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next = mem_ready ? S_WB_MEM : S_MEMRD;
      S_MEMWR:   next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R, S_EXEC_I: next = S_WB_ALU;
      S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: next = S_FETCH;
      default:   next = state;
    endcase
  end
  // every completed instruction returns to FETCH from a non-fetch state; halt retires on entry
  assign retire = (next == S_FETCH && state != S_FETCH && state != S_IDLE) ||
                  (next == S_HALT && state == S_DECODE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= OP_LW;
      retired <= '0;
    end else begin
      state <= next;
      if (state == S_DECODE) op_q <= opcode_e'(opcode[2:0]);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end
  mcu_output_decode u_decode (
    .state(state),
    .op_q(op_q),
    .mem_ready(mem_ready),
    .ctrl(ctrl)
  );
  assign PCWrite = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSrc = ctrl.pc_src;
  assign IorD = ctrl.iord;
  assign IRWrite = ctrl.ir_write;
  assign RegDst = ctrl.reg_dst;
  assign RegWrite = ctrl.reg_write;
  assign MemRead = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign MemtoReg = ctrl.mem_to_reg;
  assign ALUSrcA = ctrl.alu_src_a;
  assign ALUSrcB = ctrl.alu_src_b;
  assign ALUOp = ALUOP_W'(ctrl.alu_op);
  assign halted = ctrl.halted;
  assign illegal = ctrl.illegal;
  assign state_o = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction streams checked against a per-instruction phase model
module tb_multicycle_control_unit;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADDR = 3, P_MEMRD = 4, P_WBMEM = 5,
                 P_MEMWR = 6, P_EXECR = 7, P_EXECI = 8, P_WBALU = 9, P_BRANCH = 10, P_JUMP = 11,
                 P_HALT = 12, P_TRAP = 13;
  logic clk = 0, rst_n = 0, start = 0, mem_ready = 0;
  logic [3:0] opcode = 0;
  logic a_pcw, a_pcwc, a_iord, a_irw, a_rdst, a_rw, a_mrd, a_mwr, a_m2r, a_srca, a_hlt, a_ill;
  logic b_pcw, b_pcwc, b_iord, b_irw, b_rdst, b_rw, b_mrd, b_mwr, b_m2r, b_srca, b_hlt, b_ill;
  logic [1:0] a_pcsrc, a_srcb, b_pcsrc, b_srcb, b_aluop, b_ret;
  logic [2:0] a_aluop;
  logic [15:0] a_ret;
  logic [3:0] a_st, b_st;
  logic [18:0] a_ctrl;
  logic [17:0] b_ctrl;
  int checks = 0, failures = 0, cnt = 0;
  bit b_on = 1, start_v = 0;
  always #5 clk = ~clk;
  assign a_ctrl = {a_pcw, a_pcwc, a_pcsrc, a_iord, a_irw, a_rdst, a_rw, a_mrd, a_mwr, a_m2r, a_srca, a_srcb, a_aluop, a_hlt, a_ill};
  assign b_ctrl = {b_pcw, b_pcwc, b_pcsrc, b_iord, b_irw, b_rdst, b_rw, b_mrd, b_mwr, b_m2r, b_srca, b_srcb, b_aluop, b_hlt, b_ill};
  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .PCSrc(a_pcsrc), .IorD(a_iord), .IRWrite(a_irw),
    .RegDst(a_rdst), .RegWrite(a_rw), .MemRead(a_mrd), .MemWrite(a_mwr), .MemtoReg(a_m2r),
    .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALUOp(a_aluop), .halted(a_hlt), .illegal(a_ill),
    .retired(a_ret), .state_o(a_st));
  multicycle_control_unit #(.OPCODE_W(3), .ALUOP_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode[2:0]), .mem_ready(mem_ready),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .PCSrc(b_pcsrc), .IorD(b_iord), .IRWrite(b_irw),
    .RegDst(b_rdst), .RegWrite(b_rw), .MemRead(b_mrd), .MemWrite(b_mwr), .MemtoReg(b_m2r),
    .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALUOp(b_aluop), .halted(b_hlt), .illegal(b_ill),
    .retired(b_ret), .state_o(b_st));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected control bundle for one phase, straight from the per-state output table
  function automatic logic [18:0] exp_ctrl(input int ph, input int op, input bit mr);
    logic pcw, pcwc, iord, irw, rdst, rw, mrd, mwr, m2r, srca, hlt, ill;
    logic [1:0] pcsrc, srcb;
    logic [2:0] aluop;
    {pcw, pcwc, iord, irw, rdst, rw, mrd, mwr, m2r, srca, hlt, ill} = '0;
    pcsrc = '0;
    srcb = '0;
    aluop = '0;
    case (ph)
      P_FETCH:   begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      P_DECODE:  srcb = 2'b11;
      P_MEMADDR: begin srca = 1; srcb = 2'b10; end
      P_MEMRD:   begin mrd = 1; iord = 1; end
      P_WBMEM:   begin rw = 1; m2r = 1; end
      P_MEMWR:   begin mwr = 1; iord = 1; end
      P_EXECR:   begin srca = 1; aluop = (op == 4) ? 3'b010 : 3'b000; end
      P_EXECI:   begin srca = 1; srcb = 2'b10; end
      P_WBALU:   begin rw = 1; rdst = (op != 3); end
      P_BRANCH:  begin srca = 1; aluop = 3'b001; pcwc = 1; pcsrc = 2'b01; end
      P_JUMP:    begin pcw = 1; pcsrc = 2'b10; end
      P_HALT:    hlt = 1;
      P_TRAP:    ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcsrc, iord, irw, rdst, rw, mrd, mwr, m2r, srca, srcb, aluop, hlt, ill};
  endfunction

  task automatic step(input int ph, input int op, input bit mr);
    logic [18:0] e;
    @(negedge clk);
    opcode = (ph == P_DECODE) ? 4'(op) : 4'($urandom);
    mem_ready = mr;
    start = (ph == P_IDLE) ? start_v : 1'($urandom);
    #1;
    e = exp_ctrl(ph, op, mr);
    chk($sformatf("ctrl_ph%0d_op%0d", ph, op), 32'(a_ctrl), 32'(e));
    chk("retired", 32'(a_ret), 32'(cnt[15:0]));
    if (ph == P_IDLE) chk("state_idle", 32'(a_st), 32'd0);
    if (b_on) begin
      chk($sformatf("b_ctrl_ph%0d", ph), 32'(b_ctrl), 32'({e[18:5], e[3:0]}));
      chk("b_retired", 32'(b_ret), 32'(cnt[1:0]));
    end
  endtask

  task automatic boot();
    @(negedge clk);
    rst_n = 0;
    start = 0;
    cnt = 0;
    #1;
    chk("rst_ctrl", 32'(a_ctrl), 32'd0);
    chk("rst_state", 32'(a_st), 32'd0);
    chk("rst_retired", 32'(a_ret), 32'd0);
    rst_n = 1;
    start_v = 0;
    step(P_IDLE, 0, 0);
    step(P_IDLE, 0, 1);
    start_v = 1;
    step(P_IDLE, 0, 0);
    start_v = 0;
  endtask

  task automatic do_instr(input int op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) step(P_FETCH, op, 0);
    step(P_FETCH, op, 1);
    step(P_DECODE, op, 1'($urandom));
    if (op > 7) begin
      step(P_TRAP, op, 1'($urandom));
      return;
    end
    case (op)
      0: begin
        step(P_MEMADDR, op, 1'($urandom));
        for (int i = 0; i < wm; i++) step(P_MEMRD, op, 0);
        step(P_MEMRD, op, 1);
        step(P_WBMEM, op, 1'($urandom));
      end
      1: begin
        step(P_MEMADDR, op, 1'($urandom));
        for (int i = 0; i < wm; i++) step(P_MEMWR, op, 0);
        step(P_MEMWR, op, 1);
      end
      2, 4: begin step(P_EXECR, op, 1'($urandom)); step(P_WBALU, op, 1'($urandom)); end
      3: begin step(P_EXECI, op, 1'($urandom)); step(P_WBALU, op, 1'($urandom)); end
      5: step(P_JUMP, op, 1'($urandom));
      6: step(P_BRANCH, op, 1'($urandom));
      default: begin
        cnt++;
        step(P_HALT, op, 1'($urandom));
        return;
      end
    endcase
    cnt++;
  endtask

  initial begin
    boot();
    do_instr(2, 0, 0);
    do_instr(0, 0, 3);
    do_instr(6, 0, 0);
    do_instr(5, 0, 0);
    do_instr(4, 1, 0);
    do_instr(3, 0, 0);
    do_instr(1, 2, 2);
    repeat (60) do_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2));
    step(P_FETCH, 1, 1);
    step(P_DECODE, 1, 0);
    step(P_MEMADDR, 1, 1);
    step(P_MEMWR, 1, 0);
    step(P_MEMWR, 1, 0);
    boot();
    do_instr(7, 0, 0);
    repeat (12) step(P_HALT, 7, 1'($urandom));
    b_on = 0;
    boot();
    do_instr(9, 1, 0);
    repeat (12) step(P_TRAP, 9, 1'($urandom));
    b_on = 1;
    boot();
    repeat (5) do_instr(2, 0, 0);
    step(P_FETCH, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
